// File: rtl/relu_backward.sv
// Stores one ReLU "active" mask per forward vector and applies them in order to gradient vectors.
// Latency: 1 cycle grad_in->grad_out. Backpressure: output register holds while !grad_out_ready; grad_in stalls then.
module relu_backward #(
    parameter int DATA_WIDTH = 32,
    parameter int N_ELEM     = 4,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         fwd_valid,
    output logic                         fwd_ready,
    input  logic [N_ELEM*DATA_WIDTH-1:0] fwd_data,
    input  logic                         grad_in_valid,
    output logic                         grad_in_ready,
    input  logic [N_ELEM*DATA_WIDTH-1:0] grad_in,
    output logic                         grad_out_valid,
    input  logic                         grad_out_ready,
    output logic [N_ELEM*DATA_WIDTH-1:0] grad_out,
    output logic [$clog2(DEPTH):0]       mask_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int VW = N_ELEM * DATA_WIDTH;

    logic [N_ELEM-1:0] mask_mem [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              grad_out_valid_q, grad_out_valid_d;
    logic [VW-1:0]     grad_out_q, grad_out_d;

    logic [N_ELEM-1:0] fwd_mask;
    logic [N_ELEM-1:0] rd_mask;
    logic [VW-1:0]     masked_grad;
    logic              push;
    logic              pop;

    // Strictly positive only: zero and the most negative value both give 0.
    always_comb begin
        fwd_mask    = '0;
        masked_grad = '0;
        rd_mask     = mask_mem[rd_ptr_q];
        for (int i = 0; i < N_ELEM; i++) begin
            fwd_mask[i] = !fwd_data[i*DATA_WIDTH + DATA_WIDTH - 1] &&
                          (fwd_data[i*DATA_WIDTH +: DATA_WIDTH] != '0);
            masked_grad[i*DATA_WIDTH +: DATA_WIDTH] =
                rd_mask[i] ? grad_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    assign fwd_ready     = !flush && (count_q < CW'(DEPTH));
    assign grad_in_ready = !flush && (count_q != '0) && (!grad_out_valid_q || grad_out_ready);
    assign push          = fwd_valid && fwd_ready;
    assign pop           = grad_in_valid && grad_in_ready;

    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        grad_out_valid_d = grad_out_valid_q;
        grad_out_d       = grad_out_q;
        if (flush) begin
            wr_ptr_d         = '0;
            rd_ptr_d         = '0;
            count_d          = '0;
            grad_out_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d         = rd_ptr_q + PW'(1);
                grad_out_d       = masked_grad;
                grad_out_valid_d = 1'b1;
            end else if (grad_out_ready) begin
                grad_out_valid_d = 1'b0;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            grad_out_valid_q <= 1'b0;
            grad_out_q       <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            grad_out_valid_q <= grad_out_valid_d;
            grad_out_q       <= grad_out_d;
        end
    end

    // Mask storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wr_ptr_q] <= fwd_mask;
        end
    end

    assign grad_out_valid = grad_out_valid_q;
    assign grad_out       = grad_out_q;
    assign mask_count     = count_q;

endmodule

// File: tb/tb_relu_backward.sv
// Randomized and directed bench for relu_backward with a queue-based reference model.
module tb_relu_backward;
    localparam int DW    = 32;
    localparam int NE    = 4;
    localparam int DEPTH = 16;
    localparam int VW    = NE * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          fwd_valid = 1'b0;
    logic          grad_in_valid = 1'b0;
    logic          grad_out_ready = 1'b1;
    logic [VW-1:0] fwd_data = '0;
    logic [VW-1:0] grad_in = '0;
    logic          fwd_ready;
    logic          grad_in_ready;
    logic          grad_out_valid;
    logic [VW-1:0] grad_out;
    logic [4:0]    mask_count;

    int checks = 0;
    int errors = 0;

    logic [NE-1:0] mq[$];
    logic          m_ov = 1'b0;
    logic [VW-1:0] m_od = '0;

    relu_backward #(.DATA_WIDTH(DW), .N_ELEM(NE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
        .grad_in_valid(grad_in_valid), .grad_in_ready(grad_in_ready), .grad_in(grad_in),
        .grad_out_valid(grad_out_valid), .grad_out_ready(grad_out_ready), .grad_out(grad_out),
        .mask_count(mask_count)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] pack4(input logic [31:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    function automatic logic [NE-1:0] relu_mask(input logic [VW-1:0] v);
        logic [NE-1:0] m;
        for (int i = 0; i < NE; i++) m[i] = ($signed(v[i*DW +: DW]) > 0);
        return m;
    endfunction

    function automatic logic [VW-1:0] apply_mask(input logic [NE-1:0] m, input logic [VW-1:0] g);
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < NE; i++) if (m[i]) r[i*DW +: DW] = g[i*DW +: DW];
        return r;
    endfunction

    function automatic logic [31:0] rnd_elem();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'h1;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        return pack4(rnd_elem(), rnd_elem(), rnd_elem(), rnd_elem());
    endfunction

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: compare on the falling edge, then advance to the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            m_ov = 1'b0;
            m_od = '0;
        end else begin
            logic exp_f, exp_g, do_push, do_pop;
            exp_f = !flush && (mq.size() < DEPTH);
            exp_g = !flush && (mq.size() != 0) && (!m_ov || grad_out_ready);
            chkn("m_fwd_ready", int'(fwd_ready), int'(exp_f));
            chkn("m_grad_in_ready", int'(grad_in_ready), int'(exp_g));
            chkn("m_grad_out_valid", int'(grad_out_valid), int'(m_ov));
            chkn("m_mask_count", int'(mask_count), mq.size());
            if (m_ov) chkv("m_grad_out", grad_out, m_od);
            if (flush) begin
                mq.delete();
                m_ov = 1'b0;
            end else begin
                do_push = fwd_valid && exp_f;
                do_pop  = grad_in_valid && exp_g;
                if (do_pop) begin
                    m_od = apply_mask(mq.pop_front(), grad_in);
                    m_ov = 1'b1;
                end else if (grad_out_ready) begin
                    m_ov = 1'b0;
                end
                if (do_push) mq.push_back(relu_mask(fwd_data));
            end
        end
    end

    initial begin
        logic [VW-1:0] hold;
        int pushes, pops;

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chkn("rst_count", int'(mask_count), 0);
        chkn("rst_valid", int'(grad_out_valid), 0);
        chkv("rst_grad_out", grad_out, '0);
        chkn("rst_fwd_ready", int'(fwd_ready), 1);
        chkn("rst_grad_in_ready", int'(grad_in_ready), 0);

        // Single vector: mask 1001b
        fwd_data = pack4(32'd5, 32'd0, 32'hFFFF_FFFD, 32'h7FFF_FFFF);
        fwd_valid = 1'b1;
        tick();
        fwd_valid = 1'b0;
        chkn("t1_count", int'(mask_count), 1);
        grad_in = pack4(32'd10, 32'd20, 32'd30, 32'd40);
        grad_in_valid = 1'b1;
        tick();
        grad_in_valid = 1'b0;
        chkv("t1_grad_out", grad_out, pack4(32'd10, 32'd0, 32'd0, 32'd40));
        chkn("t1_valid", int'(grad_out_valid), 1);
        chkn("t1_count_after", int'(mask_count), 0);
        tick();

        // Edge values
        fwd_data = pack4(32'h8000_0000, 32'd1, 32'd0, 32'hFFFF_FFFF);
        fwd_valid = 1'b1;
        tick();
        fwd_valid = 1'b0;
        grad_in = pack4(32'd7, 32'd7, 32'd7, 32'd7);
        grad_in_valid = 1'b1;
        tick();
        grad_in_valid = 1'b0;
        chkv("t2_grad_out", grad_out, pack4(32'd0, 32'd7, 32'd0, 32'd0));
        tick();

        // Fill to full, hold a 17th, then one pop reopens the FIFO
        fwd_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_data = rnd_vec();
            chkn("fill_fwd_ready", int'(fwd_ready), 1);
            tick();
        end
        chkn("full_count", int'(mask_count), 16);
        chkn("full_fwd_ready", int'(fwd_ready), 0);
        tick();
        chkn("full_hold_count", int'(mask_count), 16);
        fwd_valid = 1'b0;
        grad_in = rnd_vec();
        grad_in_valid = 1'b1;
        tick();
        grad_in_valid = 1'b0;
        chkn("after_pop_fwd_ready", int'(fwd_ready), 1);
        chkn("after_pop_count", int'(mask_count), 15);
        grad_in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            grad_in = rnd_vec();
            tick();
        end
        grad_in_valid = 1'b0;
        tick();
        chkn("drain_count", int'(mask_count), 0);

        // Backpressure with three all-active masks
        fwd_data = pack4(32'd1, 32'd2, 32'd3, 32'd4);
        fwd_valid = 1'b1;
        repeat (3) tick();
        fwd_valid = 1'b0;
        grad_out_ready = 1'b0;
        grad_in = pack4(32'h11, 32'h12, 32'h13, 32'h14);
        grad_in_valid = 1'b1;
        tick();
        chkn("bp_grad_in_ready", int'(grad_in_ready), 0);
        chkn("bp_count", int'(mask_count), 2);
        chkv("bp_first", grad_out, pack4(32'h11, 32'h12, 32'h13, 32'h14));
        hold = grad_out;
        grad_in = pack4(32'h21, 32'h22, 32'h23, 32'h24);
        for (int i = 0; i < 5; i++) begin
            tick();
            chkv("bp_stable", grad_out, hold);
            chkn("bp_valid", int'(grad_out_valid), 1);
        end
        grad_out_ready = 1'b1;
        tick();
        chkv("bp_second", grad_out, pack4(32'h21, 32'h22, 32'h23, 32'h24));
        grad_in = pack4(32'h31, 32'h32, 32'h33, 32'h34);
        tick();
        grad_in_valid = 1'b0;
        chkv("bp_third", grad_out, pack4(32'h31, 32'h32, 32'h33, 32'h34));
        chkn("bp_count_end", int'(mask_count), 0);
        tick();

        // Wrap-around: concurrent push/pop with alternating masks
        pushes = 0;
        pops = 0;
        for (int c = 0; c < 100 && pops < 40; c++) begin
            fwd_valid = (pushes < 40);
            fwd_data = pushes[0] ? pack4(32'd0, 32'd8, 32'hFFFF_FFFB, 32'd2)
                                 : pack4(32'd3, 32'hFFFF_FFFF, 32'd9, 32'd0);
            grad_in_valid = 1'b1;
            grad_in = rnd_vec();
            if (fwd_valid && fwd_ready) pushes++;
            if (grad_in_valid && grad_in_ready) pops++;
            tick();
        end
        fwd_valid = 1'b0;
        grad_in_valid = 1'b0;
        chkn("wrap_pops", pops, 40);
        tick();

        // Flush with 5 stored masks and a held output
        grad_out_ready = 1'b0;
        fwd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fwd_data = rnd_vec();
            tick();
        end
        fwd_valid = 1'b0;
        grad_in = rnd_vec();
        grad_in_valid = 1'b1;
        tick();
        grad_in_valid = 1'b0;
        chkn("fl_pre_count", int'(mask_count), 5);
        chkn("fl_pre_valid", int'(grad_out_valid), 1);
        flush = 1'b1;
        fwd_valid = 1'b1;
        grad_in_valid = 1'b1;
        grad_out_ready = 1'b1;
        #1;
        chkn("fl_fwd_ready", int'(fwd_ready), 0);
        chkn("fl_grad_in_ready", int'(grad_in_ready), 0);
        tick();
        flush = 1'b0;
        fwd_valid = 1'b0;
        grad_in_valid = 1'b0;
        chkn("fl_count", int'(mask_count), 0);
        chkn("fl_valid", int'(grad_out_valid), 0);
        chkn("fl_grad_in_ready_after", int'(grad_in_ready), 0);
        tick();

        // Asynchronous reset between clock edges
        grad_out_ready = 1'b0;
        fwd_data = pack4(32'd1, 32'd1, 32'd1, 32'd1);
        fwd_valid = 1'b1;
        repeat (3) tick();
        fwd_valid = 1'b0;
        grad_in = pack4(32'd9, 32'd9, 32'd9, 32'd9);
        grad_in_valid = 1'b1;
        tick();
        grad_in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chkn("ar_count", int'(mask_count), 0);
        chkn("ar_valid", int'(grad_out_valid), 0);
        chkv("ar_grad_out", grad_out, '0);
        chkn("ar_grad_in_ready", int'(grad_in_ready), 0);
        tick();
        rst = 1'b0;
        grad_out_ready = 1'b1;
        tick();

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            fwd_valid = ($urandom_range(0, 2) != 0);
            fwd_data = rnd_vec();
            grad_in_valid = ($urandom_range(0, 2) != 0);
            grad_in = rnd_vec();
            grad_out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 99) == 0);
            tick();
        end
        fwd_valid = 1'b0;
        grad_in_valid = 1'b0;
        flush = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/relu_backward.md
Name: relu_backward

Overview:
- Backward-pass counterpart of the combinational forward ReLU stage.
- Captures a 1-bit-per-element "active" mask from each forward pre-activation vector into a FIFO.
- Later applies those masks, in the same order, to incoming gradient vectors: grad_out[i] = mask[i] ? grad_in[i] : 0.
- Sits between the systolic array's gradient output and the previous layer's gradient input. Valid/ready on all streams.

Parameters:
- DATA_WIDTH, 32, bits per signed element (activations and gradients).
- N_ELEM, 4, elements per vector.
- DEPTH, 16, mask FIFO entries; must be a power of 2, ≥2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of mask FIFO and output register.
- fwd_valid  input  1  forward pre-activation vector valid.
- fwd_ready  output  1  mask FIFO can accept.
- fwd_data  input  N_ELEM*DATA_WIDTH  forward pre-activations; element i at [i*DATA_WIDTH +: DATA_WIDTH].
- grad_in_valid  input  1  upstream gradient vector valid.
- grad_in_ready  output  1  gradient accepted this cycle.
- grad_in  input  N_ELEM*DATA_WIDTH  gradient vector, same packing.
- grad_out_valid  output  1  masked gradient valid.
- grad_out_ready  input  1  downstream accepts.
- grad_out  output  N_ELEM*DATA_WIDTH  masked gradient.
- mask_count  output  $clog2(DEPTH)+1  masks currently stored.

Behaviour:
- Reset (async, rst=1): wr/rd pointers=0, mask_count=0, grad_out_valid=0, grad_out=0. Mask storage is not reset.
- Mask rule per element:
  - mask[i] = 1 iff the signed value is strictly > 0 (MSB=0 and value≠0).
  - Zero gives mask 0, i.e. derivative at 0 is defined as 0.
  - The most negative value gives mask 0.
- Push: fwd_ready = (mask_count < DEPTH). Push occurs when fwd_valid && fwd_ready; the N_ELEM-bit mask is written at wr_ptr, which then increments. No pass-through: the new mask is poppable from the next cycle.
- Pop/apply:
  - grad_in_ready = (mask_count ≠ 0) && (!grad_out_valid || grad_out_ready).
  - On grad_in_valid && grad_in_ready: read the mask at rd_ptr, register the masked vector into grad_out, set grad_out_valid=1, increment rd_ptr.
- Latency/throughput: one cycle grad_in→grad_out; one vector per cycle sustained while downstream is ready.
- Output hold: while grad_out_valid && !grad_out_ready, grad_out and grad_out_valid are stable. The output clears valid only on a handshake with no new accept in that cycle.
- Simultaneous push and pop: both occur, mask_count unchanged. Pointers wrap modulo DEPTH (natural rollover, no extra logic).
- Full: fwd_ready=0 even if a pop occurs in the same cycle (no same-cycle slot reuse).
- Empty: grad_in_ready=0 even if a push occurs in the same cycle.
- Flush:
  - Next edge sets pointers and count to 0 and grad_out_valid to 0. grad_out data is don't-care after flush.
  - Flush overrides push and pop in the same cycle; no handshakes complete that cycle. fwd_ready and grad_in_ready are forced 0 while flush=1.
- Reset mid-stream: all state cleared immediately; in-flight vectors are discarded. Upstream must restart the forward pass.
- Width: no arithmetic on data; gradients pass bit-exact or become all-zero per element.

Test Plan:
- Reset then single vector:
  - Push fwd_data = {5, 0, -3, 0x7FFFFFFF} (elements 0..3) → mask 1001b, mask_count=1.
  - Then grad_in = {10, 20, 30, 40} → next cycle grad_out={10, 0, 0, 40}, grad_out_valid=1, mask_count=0.
- Edge values: fwd elements {0x80000000, 1, 0, -1} with grad {7, 7, 7, 7} → grad_out={0, 7, 0, 0}.
- Fill/full:
  - Push 16 vectors with fwd_ready held high throughout → count=16, fwd_ready=0.
  - 17th fwd_valid is held with no count change.
  - One pop → fwd_ready=1 the following cycle.
- Backpressure:
  - Hold grad_out_ready=0 with 3 masks stored and grad_in_valid=1 → exactly one vector is accepted, then grad_in_ready=0.
  - grad_out stays stable for 5 cycles.
  - Release → remaining two vectors stream back-to-back, order preserved.
- Wrap-around: stream 40 vectors with concurrent push/pop and alternating masks 0101b/1010b → every output matches its in-order mask; count never exceeds 16.
- Flush and async reset:
  - With 5 masks stored and grad_out_valid=1, pulse flush → count=0, grad_out_valid=0, grad_in_ready=0.
  - Separately, assert rst mid-stream between clock edges → outputs reset immediately without a clock edge.
